mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped responder on the core's data-memory port that gives the RISC-V core a byte-serial console and a `tohost` exit register. It sits beside `dmem0` on the same `dmem_*` address/write/strobe/read-data signals and responds only in its own address window. Byte writes to the data register enter a TX FIFO and are serialized as 8N1 UART frames. Reads return a status word with the same one-cycle latency as `ram`.

## Interface
Parameters:
- `XLEN`, 32, data/address width; `XBYTES = XLEN/8`.
- `UART_ADDR`, 32'h4000_0000, word address of the TX data register; the status register is at `UART_ADDR+4`.
- `TOHOST_ADDR`, `` `TOHOST_ADDR ``, word address of the tohost register.
- `CLK_DIV`, 16, clock cycles per UART bit; legal range ≥2.
- `FIFO_DEPTH`, 8, TX FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `dmem_addr_i`  in  XLEN  byte address shared by read and write.
- `dmem_wvalid_i`  in  1  write strobe for this cycle.
- `dmem_wstrb_i`  in  XBYTES  byte enables.
- `dmem_wdata_i`  in  XLEN  write data.
- `dmem_rdata_o`  out  XLEN  registered read data.
- `uart_tx_o`  out  1  serial line; idles high.
- `tohost_valid_o`  out  1  sticky flag, set by the first tohost write.
- `tohost_data_o`  out  XLEN  value of the last tohost write.

## Operation
- Address decode compares `dmem_addr_i[XLEN-1:2]` with each register's word address. Bits [1:0] are ignored.
- Data-register write: `wvalid && wstrb[0]` at `UART_ADDR` pushes `wdata[7:0]`. Writes with `wstrb[0]=0` are ignored.
  - FIFO full and no pop in the same cycle: the byte is dropped and sticky `ovf` is set.
  - FIFO full with a pop in the same cycle: the push is accepted and the count is unchanged.
- Status register, read-only except for `ovf`:
  - bit0 = `full`
  - bit1 = `busy` (FSM is not IDLE, or FIFO is not empty)
  - bit2 = `ovf`
  - bits[15:8] = FIFO count
  - all other bits 0
  - Any write to `UART_ADDR+4` clears `ovf`. If an overflow happens in the same cycle as the clear, `ovf` ends up set.
- Reads at `UART_ADDR` return 0. Reads at `TOHOST_ADDR` return `tohost_data_o`. Reads outside the window return 0. The core ORs or muxes this with `dmem0`; that is a top-level concern.
- Tohost register: any write with a nonzero `wstrb` to `TOHOST_ADDR` writes the whole word. It sets `tohost_valid_o`, which stays set until reset.
- TX FSM states: `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE`: if the FIFO is not empty, pop into the shift register and go to `START`.
  - `START`: drive 0 for `CLK_DIV` cycles, then go to `DATA`.
  - `DATA`: drive bits LSB first, `CLK_DIV` cycles each. The 3-bit counter goes from 0 to 7, then go to `STOP`.
  - `STOP`: drive 1 for `CLK_DIV` cycles, then go to `IDLE`.
- The baud counter counts down from `CLK_DIV-1` to 0 and reloads on each bit boundary.

## Timing
- Reset values:
  - `uart_tx_o` = 1
  - `dmem_rdata_o` = 0
  - `tohost_valid_o` = 0
  - `tohost_data_o` = 0
  - FIFO empty, `ovf` = 0, FSM in `IDLE`
- Reset mid-frame: `uart_tx_o` returns to 1 in the cycle after reset is sampled, and FIFO contents are discarded.
- Read latency is 1 cycle: `dmem_rdata_o` at t+1 reflects the address at t and state at t. A status read in the same cycle as a push shows the pre-push count.
- Write at cycle t, FIFO empty and FSM in `IDLE`:
  - FIFO is not empty at t+1.
  - Pop happens at t+1.
  - `uart_tx_o` = 0 from t+2.
- Frame length is exactly 10·`CLK_DIV` cycles.
- Back-to-back bytes have exactly one idle-high cycle between frames: the `IDLE` cycle after `STOP`.
- `tohost_valid_o`/`tohost_data_o` update at t+1 after the write cycle.

## Structure
- Shared package `rvbug_pkg`:
  - address constants `UART_ADDR`, `UART_STAT_ADDR`
  - status bit indices `STAT_FULL`, `STAT_BUSY`, `STAT_OVF`
  - UART FSM state enum
- Sub-module `sync_fifo`, parameterized by `WIDTH`/`DEPTH`:
  - ports: push, pop, din, dout, full, empty, count
  - simultaneous push+pop allowed when full or empty
  - `dout` is valid combinationally whenever not empty

## Test plan
- Reset, idle 50 cycles: `uart_tx_o`=1, status read returns 0, `tohost_valid_o`=0.
- Write 0x55 to `UART_ADDR` with `CLK_DIV`=16: the line decodes as start 0, bits 1,0,1,0,1,0,1,0, stop 1. Each bit is held 16 cycles, the start edge is at t+2, and the frame is 160 cycles long.
- Write 9 bytes back-to-back with `FIFO_DEPTH`=8:
  - The first byte is popped immediately and 8 are queued, so nothing is dropped.
  - A 10th write sets `ovf`: a status read shows bit2=1, bit0=1, count=8.
  - Writing to `UART_ADDR+4` clears bit2.
- Write with `wstrb`=4'b0010 to `UART_ADDR`: no push and the line stays idle.
- Write 0x0000_0001 to `TOHOST_ADDR`: `tohost_valid_o`=1 and `tohost_data_o`=1 at t+1, and a read of `TOHOST_ADDR` returns 1.
- Assert `rst_i` halfway through a frame with 3 bytes queued: `uart_tx_o`=1 at the next cycle, status count=0, and no further frames.

Source files
------------

// File: rtl/rvbug_pkg.sv
// Shared address map, status-bit layout and UART FSM encoding for the
// RISC-V bring-up MMIO peripherals.
`ifndef TOHOST_ADDR
`define TOHOST_ADDR 32'h8000_1000
`endif

package rvbug_pkg;

  localparam logic [31:0] UART_ADDR      = 32'h4000_0000;
  localparam logic [31:0] UART_STAT_ADDR = UART_ADDR + 32'd4;

  localparam int STAT_FULL    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, pointer based; dout shows the head entry combinationally.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO console: byte writes queue into a TX FIFO and leave as 8N1 frames; status/tohost
// reads return one cycle later. Writes never stall: a push into a full FIFO is dropped and flagged.
`ifndef TOHOST_ADDR
`define TOHOST_ADDR 32'h8000_1000
`endif

module mmio_uart_tx #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] UART_ADDR   = XLEN'(rvbug_pkg::UART_ADDR),
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(`TOHOST_ADDR),
  parameter int              CLK_DIV     = 16,
  parameter int              FIFO_DEPTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [XLEN-1:0]      dmem_addr_i,
  input  logic                 dmem_wvalid_i,
  input  logic [XLEN/8-1:0]    dmem_wstrb_i,
  input  logic [XLEN-1:0]      dmem_wdata_i,
  output logic [XLEN-1:0]      dmem_rdata_o,
  output logic                 uart_tx_o,
  output logic                 tohost_valid_o,
  output logic [XLEN-1:0]      tohost_data_o
);

  import rvbug_pkg::*;

  localparam int              CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int              BW          = $clog2(CLK_DIV);
  localparam logic [BW-1:0]   BAUD_RELOAD = BW'(CLK_DIV - 1);
  localparam logic [XLEN-1:0] STAT_ADDR   = UART_ADDR + XLEN'(4);

  logic [XLEN-3:0] word_addr;
  logic            hit_data;
  logic            hit_stat;
  logic            hit_tohost;
  logic            unused_addr_bits;

  logic            push;
  logic            overflow;
  logic            stat_wr;
  logic            tohost_wr;
  logic            ovf;

  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;

  uart_state_e     state;
  logic [BW-1:0]   baud;
  logic            baud_done;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            tx;

  logic [XLEN-1:0] status_word;
  logic [XLEN-1:0] rdata_next;

  // Registers are word-addressed; the byte offset never matters.
  assign word_addr        = dmem_addr_i[XLEN-1:2];
  assign unused_addr_bits = ^dmem_addr_i[1:0];
  assign hit_data         = (word_addr == UART_ADDR[XLEN-1:2]);
  assign hit_stat         = (word_addr == STAT_ADDR[XLEN-1:2]);
  assign hit_tohost       = (word_addr == TOHOST_ADDR[XLEN-1:2]);

  assign push      = dmem_wvalid_i && dmem_wstrb_i[0] && hit_data;
  assign overflow  = push && fifo_full && !fifo_pop;
  assign stat_wr   = dmem_wvalid_i && hit_stat;
  assign tohost_wr = dmem_wvalid_i && (|dmem_wstrb_i) && hit_tohost;

  assign fifo_pop  = (state == UART_IDLE) && !fifo_empty;
  assign baud_done = (baud == '0);
  assign uart_tx_o = tx;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (fifo_pop),
    .din   (dmem_wdata_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word                                   = '0;
    status_word[STAT_FULL]                        = fifo_full;
    status_word[STAT_BUSY]                        = (state != UART_IDLE) || !fifo_empty;
    status_word[STAT_OVF]                         = ovf;
    status_word[STAT_CNT_LSB +: STAT_CNT_W]       = STAT_CNT_W'(fifo_count);
  end

  always_comb begin
    rdata_next = '0;
    if (hit_stat)        rdata_next = status_word;
    else if (hit_tohost) rdata_next = tohost_data_o;
  end

  // An overflow in the same cycle as a clearing write wins, so no drop goes unreported.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf            <= 1'b0;
      tohost_valid_o <= 1'b0;
      tohost_data_o  <= '0;
      dmem_rdata_o   <= '0;
    end else begin
      if (overflow)     ovf <= 1'b1;
      else if (stat_wr) ovf <= 1'b0;
      if (tohost_wr) begin
        tohost_valid_o <= 1'b1;
        tohost_data_o  <= dmem_wdata_i;
      end
      dmem_rdata_o <= rdata_next;
    end
  end

  // The line is registered; each state drives its level for a full CLK_DIV period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= UART_IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        UART_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shreg <= fifo_dout;
            baud  <= BAUD_RELOAD;
            tx    <= 1'b0;
            state <= UART_START;
          end
        end
        UART_START: begin
          if (baud_done) begin
            baud    <= BAUD_RELOAD;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= UART_DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        UART_DATA: begin
          if (baud_done) begin
            baud <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= UART_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        UART_STOP: begin
          if (baud_done) state <= UART_IDLE;
          else           baud  <= baud - 1'b1;
        end
        default: begin
          state <= UART_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random MMIO traffic, all checked
// every cycle against a frame-level model of the console.
module tb_mmio_uart_tx;

  localparam int          CLK_DIV = 16;
  localparam int          DEPTH   = 8;
  localparam int          FRAME   = 10 * CLK_DIV;
  localparam logic [31:0] U_ADDR  = 32'h4000_0000;
  localparam logic [31:0] S_ADDR  = 32'h4000_0004;
  localparam logic [31:0] T_ADDR  = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wvalid;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        th_v;
  logic [31:0] th_d;

  mmio_uart_tx #(
    .XLEN        (32),
    .UART_ADDR   (U_ADDR),
    .TOHOST_ADDR (T_ADDR),
    .CLK_DIV     (CLK_DIV),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .dmem_addr_i    (addr),
    .dmem_wvalid_i  (wvalid),
    .dmem_wstrb_i   (wstrb),
    .dmem_wdata_i   (wdata),
    .dmem_rdata_o   (rdata),
    .uart_tx_o      (tx),
    .tohost_valid_o (th_v),
    .tohost_data_o  (th_d)
  );

  always #5 clk = ~clk;

  // Model: queued bytes, the frame on the wire (start cycle + byte), and register values.
  logic [7:0]  q[$];
  longint      cyc;
  logic        have_frame;
  longint      fstart;
  logic [7:0]  fbyte;
  logic        m_ovf;
  logic        m_tv;
  logic [31:0] m_td;
  logic [31:0] m_rd;
  int          n_checks;
  int          n_errors;

  function automatic logic hit(input logic [31:0] a, input logic [31:0] base);
    return a[31:2] == base[31:2];
  endfunction

  function automatic logic line_at(input longint c);
    longint k;
    if (!have_frame || c < fstart || c >= fstart + FRAME) return 1'b1;
    k = (c - fstart) / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return fbyte[k-1];
    return 1'b1;
  endfunction

  task automatic model_cycle();
    int          sz;
    logic        busy;
    logic        pop;
    logic        drop;
    logic [31:0] stat;
    if (rst) begin
      q.delete();
      have_frame = 1'b0;
      m_ovf      = 1'b0;
      m_tv       = 1'b0;
      m_td       = '0;
      m_rd       = '0;
    end else begin
      sz   = q.size();
      busy = (have_frame && cyc >= fstart && cyc < fstart + FRAME) || (sz > 0);
      stat = {16'h0, 8'(sz), 5'h0, m_ovf, busy, (sz == DEPTH)};
      if (hit(addr, S_ADDR))      m_rd = stat;
      else if (hit(addr, T_ADDR)) m_rd = m_td;
      else                        m_rd = '0;
      pop = (sz > 0) && !(have_frame && cyc < fstart + FRAME);
      if (pop) begin
        fbyte      = q.pop_front();
        fstart     = cyc + 1;
        have_frame = 1'b1;
      end
      drop = 1'b0;
      if (wvalid && wstrb[0] && hit(addr, U_ADDR)) begin
        if (q.size() < DEPTH) q.push_back(wdata[7:0]);
        else                  drop = 1'b1;
      end
      if (drop)                             m_ovf = 1'b1;
      else if (wvalid && hit(addr, S_ADDR)) m_ovf = 1'b0;
      if (wvalid && (|wstrb) && hit(addr, T_ADDR)) begin
        m_tv = 1'b1;
        m_td = wdata;
      end
    end
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    rst    = r;
    wvalid = v;
    wstrb  = s;
    addr   = a;
    wdata  = d;
    model_cycle();
    @(posedge clk);
    #1;
    check("uart_tx", {31'h0, tx}, {31'h0, line_at(cyc)});
    check("rdata", rdata, m_rd);
    check("tohost_valid", {31'h0, th_v}, {31'h0, m_tv});
    check("tohost_data", th_d, m_td);
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, a, 32'h0);
  endtask

  function automatic logic [31:0] pick_addr(input int k);
    logic [31:0] a;
    case (k)
      0:       a = U_ADDR;
      1:       a = S_ADDR;
      2:       a = T_ADDR;
      default: a = {4'h1, 28'($urandom)};
    endcase
    a[1:0] = 2'($urandom);
    return a;
  endfunction

  initial begin
    logic [9:0] frame_bits;
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    have_frame = 1'b0;
    fstart     = 0;
    fbyte      = '0;
    m_ovf      = 1'b0;
    m_tv       = 1'b0;
    m_td       = '0;
    m_rd       = '0;
    rst = 1'b1; wvalid = 1'b0; wstrb = '0; addr = '0; wdata = '0;

    // Reset, then a long idle with the status register being read.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, S_ADDR, 32'h0);
    idle(50, S_ADDR);
    check("idle_line", {31'h0, tx}, 32'h1);
    check("idle_status", rdata, 32'h0);
    check("idle_tohost_valid", {31'h0, th_v}, 32'h0);

    // Single 0x55 frame: sample mid-bit and at bit edges.
    step(1'b0, 1'b1, 4'b0001, U_ADDR, 32'h0000_0055);
    check("line_before_start", {31'h0, tx}, 32'h1);
    frame_bits = '0;
    for (int k = 1; k <= 165; k++) begin
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      if (k == 1)   check("start_edge_t2", {31'h0, tx}, 32'h0);
      if (k == 16)  check("start_last_cycle", {31'h0, tx}, 32'h0);
      if (k == 17)  check("bit0_first_cycle", {31'h0, tx}, 32'h1);
      if (k == 144) check("bit7_last_cycle", {31'h0, tx}, 32'h0);
      if (k == 145) check("stop_first_cycle", {31'h0, tx}, 32'h1);
      if (k >= 9 && (k - 9) % CLK_DIV == 0 && (k - 9) / CLK_DIV < 10)
        frame_bits[(k - 9) / CLK_DIV] = tx;
    end
    check("frame_0x55", {22'h0, frame_bits}, 32'h0000_02AA);

    // Nine back-to-back bytes fit (one on the wire, eight queued); the tenth overflows.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 4'b1111, U_ADDR, 32'(8'hA0 + i));
    step(1'b0, 1'b1, 4'b0001, U_ADDR, 32'h0000_00EE);
    step(1'b0, 1'b0, 4'h0, S_ADDR, 32'h0);
    check("status_after_ovf", rdata, 32'h0000_0807);
    step(1'b0, 1'b1, 4'b0000, S_ADDR, 32'h0);
    step(1'b0, 1'b0, 4'h0, S_ADDR, 32'h0);
    check("status_after_clear", rdata, 32'h0000_0803);
    idle(1700, 32'h0);

    // A write without byte lane 0 must not queue anything.
    step(1'b0, 1'b1, 4'b0010, U_ADDR, 32'h0000_AAAA);
    idle(20, S_ADDR);
    check("no_push_status", rdata, 32'h0);
    check("no_push_line", {31'h0, tx}, 32'h1);

    // tohost write and readback.
    step(1'b0, 1'b1, 4'b1111, T_ADDR, 32'h0000_0001);
    check("tohost_valid_t1", {31'h0, th_v}, 32'h1);
    check("tohost_data_t1", th_d, 32'h1);
    step(1'b0, 1'b0, 4'h0, T_ADDR, 32'h0);
    check("tohost_read", rdata, 32'h1);

    // Reset halfway through a frame with three bytes still queued.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0001, U_ADDR, 32'(8'h31 + i));
    idle(80, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    check("line_after_reset", {31'h0, tx}, 32'h1);
    step(1'b0, 1'b0, 4'h0, S_ADDR, 32'h0);
    check("status_after_reset", rdata, 32'h0);
    idle(300, 32'h0);
    check("no_frames_after_reset", {31'h0, tx}, 32'h1);

    // Random MMIO traffic.
    for (int i = 0; i < 4000; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      a = pick_addr($urandom_range(0, 3));
      if (r < 25)
        step(1'b0, 1'b1, 4'($urandom), pick_addr(0), $urandom);
      else if (r < 29)
        step(1'b0, 1'b1, 4'($urandom), pick_addr(1), $urandom);
      else if (r < 32)
        step(1'b0, 1'b1, 4'($urandom), pick_addr(2), 32'($urandom_range(0, 255)));
      else if (r < 35)
        step(1'b0, 1'b1, 4'($urandom), pick_addr(3), $urandom);
      else if (r == 99 && $urandom_range(0, 7) == 0)
        step(1'b1, 1'b0, 4'h0, a, 32'h0);
      else
        step(1'b0, 1'b0, 4'h0, a, 32'h0);
    end
    idle(20, S_ADDR);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
